// File: rtl/sti_rx.sv
// STI serial receiver: collects 8/16/24/32-bit frames from si_data, strips the
// zero-fill region and presents a 16-bit word through a one-entry valid/ready register.
module sti_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_fill,
    input  logic        cfg_msb,
    input  logic        cfg_low,
    input  logic        si_data,
    input  logic        si_valid,
    output logic [15:0] po_data,
    output logic        po_valid,
    input  logic        po_ready,
    output logic        po_fill_err,
    output logic        rx_busy,
    output logic        overrun
);

    typedef enum logic {IDLE, RX} state_t;

    state_t      state, state_nxt;
    logic [1:0]  len_q;
    logic        fill_q, msb_q, low_q;
    logic [4:0]  cnt;
    logic [31:0] frame, frame_nxt;
    logic [4:0]  last_idx;
    logic        bit_take, frame_done, po_load;
    logic [16:0] word_nxt;

    // Returns {fill_err, data} for a completed frame word.
    function automatic logic [16:0] extract(input logic [31:0] w, input logic [1:0] len,
                                            input logic fill, input logic low);
        logic [16:0] r;
        case (len)
            2'd0:    r = low ? {1'b0, 8'h00, w[7:0]} : {1'b0, w[7:0], 8'h00};
            2'd1:    r = {1'b0, w[15:0]};
            2'd2:    r = fill ? {|w[7:0], w[23:8]}   : {|w[23:16], w[15:0]};
            default: r = fill ? {|w[15:0], w[31:16]} : {|w[31:16], w[15:0]};
        endcase
        return r;
    endfunction

    always_comb begin
        last_idx   = {len_q, 3'b111};
        bit_take   = (state == RX) && si_valid && !load;
        frame_done = bit_take && (cnt == last_idx);
        frame_nxt  = frame;
        if (msb_q)
            frame_nxt = {frame[30:0], si_data};
        else
            frame_nxt[cnt] = si_data;
        word_nxt   = extract(frame_nxt, len_q, fill_q, low_q);
        po_load    = frame_done && (!po_valid || po_ready);
        state_nxt  = state;
        if (load)
            state_nxt = RX;
        else if (frame_done)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q  <= 2'd0;
            fill_q <= 1'b0;
            msb_q  <= 1'b0;
            low_q  <= 1'b0;
            cnt    <= 5'd0;
            frame  <= 32'd0;
        end else if (load) begin
            len_q  <= cfg_length;
            fill_q <= cfg_fill;
            msb_q  <= cfg_msb;
            low_q  <= cfg_low;
            cnt    <= 5'd0;
            frame  <= 32'd0;
        end else if (bit_take) begin
            frame  <= frame_nxt;
            cnt    <= cnt + 5'd1;
        end
    end

    // A completed frame replaces the held word only if that word is absent or leaving now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            po_data     <= 16'd0;
            po_fill_err <= 1'b0;
            po_valid    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (po_load) begin
                po_data     <= word_nxt[15:0];
                po_fill_err <= word_nxt[16];
                po_valid    <= 1'b1;
            end else if (po_valid && po_ready) begin
                po_valid    <= 1'b0;
            end
            if (frame_done && !po_load)
                overrun <= 1'b1;
        end
    end

    assign rx_busy = (state == RX);

endmodule
